// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the pipeline / mul-div side (master) and the
// register-file write-port arbiter (slave).
interface regfile_wb_arbiter_if;
  logic        a_valid_i;
  logic [4:0]  a_addr_i;
  logic [31:0] a_data_i;
  logic        b_valid_i;
  logic        b_ready_o;
  logic [4:0]  b_addr_i;
  logic [31:0] b_data_i;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic [4:0]  qs_addr_i;
  logic [4:0]  qt_addr_i;
  logic [4:0]  qd_addr_i;
  logic        qs_pending_o;
  logic        qt_pending_o;
  logic        qd_pending_o;
  logic        stall_o;
  logic        err_o;

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i,
    input  b_valid_i, b_addr_i, b_data_i,
    output b_ready_o,
    output RegWrite_o, RDaddr_o, RDdata_o,
    input  qs_addr_i, qt_addr_i, qd_addr_i,
    output qs_pending_o, qt_pending_o, qd_pending_o,
    output stall_o, err_o
  );

  modport master (
    output a_valid_i, a_addr_i, a_data_i,
    output b_valid_i, b_addr_i, b_data_i,
    input  b_ready_o,
    input  RegWrite_o, RDaddr_o, RDdata_o,
    output qs_addr_i, qt_addr_i, qd_addr_i,
    input  qs_pending_o, qt_pending_o, qd_pending_o,
    input  stall_o, err_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the in-order pipeline (A)
// and a FIFO-buffered multi-cycle unit (B), with a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [3:0]       STARVE_C = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_FIFO
  } sel_e;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       starve_cnt;
  logic             stall_q;
  logic             err_q;
  logic             we_q;
  logic [4:0]       rd_addr_q;
  logic [31:0]      rd_data_q;

  logic      a_eff;
  logic      fifo_ne;
  logic      push;
  logic      pop;
  logic      a_drop;
  sel_e      sel;
  wb_entry_t head;

  assign a_eff         = bus.a_valid_i && (bus.a_addr_i != 5'd0);
  assign fifo_ne       = (count != '0);
  assign bus.b_ready_o = !rst_i && (count < DEPTH_C);
  // Results for $0 complete the handshake but are never queued.
  assign push          = bus.b_valid_i && bus.b_ready_o && (bus.b_addr_i != 5'd0);
  assign head          = mem[rd_ptr];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    sel    = SEL_NONE;
    a_drop = 1'b0;
    if (stall_q && fifo_ne) begin
      sel    = SEL_FIFO;
      a_drop = a_eff;
    end else if (a_eff) begin
      sel = SEL_A;
    end else if (fifo_ne) begin
      sel = SEL_FIFO;
    end
  end

  assign pop = (sel == SEL_FIFO);

  // NOTE: the entry storage has no reset; vld and count decide what is live, so stale data is never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {bus.b_addr_i, bus.b_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: all state updates use non-blocking assignment so every register samples pre-edge values.
    if (rst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      vld        <= '0;
      starve_cnt <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_data_q  <= 32'd0;
    end else begin
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (sel)
        SEL_A: begin
          we_q      <= 1'b1;
          rd_addr_q <= bus.a_addr_i;
          rd_data_q <= bus.a_data_i;
        end
        SEL_FIFO: begin
          we_q      <= 1'b1;
          rd_addr_q <= head.addr;
          rd_data_q <= head.data;
        end
        default: we_q <= 1'b0;
      endcase

      // With a non-empty FIFO and no pop, A is necessarily the winner.
      if (pop || !fifo_ne) begin
        starve_cnt <= '0;
        stall_q    <= 1'b0;
      end else begin
        starve_cnt <= starve_cnt + 4'd1;
        if (starve_cnt + 4'd1 == STARVE_C) begin
          stall_q <= 1'b1;
        end
      end

      if (a_drop) begin
        err_q <= 1'b1;
      end
    end
  end

  logic qs_hit;
  logic qt_hit;
  logic qd_hit;

  always_comb begin
    qs_hit = 1'b0;
    qt_hit = 1'b0;
    qd_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) begin
        if (mem[i].addr == bus.qs_addr_i) qs_hit = 1'b1;
        if (mem[i].addr == bus.qt_addr_i) qt_hit = 1'b1;
        if (mem[i].addr == bus.qd_addr_i) qd_hit = 1'b1;
      end
    end
    if (we_q) begin
      if (rd_addr_q == bus.qs_addr_i) qs_hit = 1'b1;
      if (rd_addr_q == bus.qt_addr_i) qt_hit = 1'b1;
      if (rd_addr_q == bus.qd_addr_i) qd_hit = 1'b1;
    end
  end

  assign bus.qs_pending_o = qs_hit && (bus.qs_addr_i != 5'd0);
  assign bus.qt_pending_o = qt_hit && (bus.qt_addr_i != 5'd0);
  assign bus.qd_pending_o = qd_hit && (bus.qd_addr_i != 5'd0);

  assign bus.RegWrite_o = we_q;
  assign bus.RDaddr_o   = rd_addr_q;
  assign bus.RDdata_o   = rd_data_q;
  assign bus.stall_o    = stall_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared every
// cycle against a queue-based reference model of the writeback rules.
module tb_regfile_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk_i = 1'b0;
  logic rst_i;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  bit          m_stall;
  bit          m_err;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend(input logic [4:0] x);
    if (x == 5'd0) return 1'b0;
    if (m_we && m_addr == x) return 1'b1;
    foreach (mq[k]) if (mq[k].addr == x) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_err    = 1'b0;
    m_we     = 1'b0;
    m_addr   = 5'd0;
    m_data   = 32'd0;
  endtask

  // One clock edge of the arbiter's rules, applied to the model state.
  task automatic model_step(input bit rdy);
    ent_t e;
    bit   a_eff;
    bit   ne;
    bit   do_pop;
    bit   do_a;
    a_eff  = bus.a_valid_i && (bus.a_addr_i != 5'd0);
    ne     = (mq.size() != 0);
    do_pop = 1'b0;
    do_a   = 1'b0;
    if (m_stall && ne) begin
      do_pop = 1'b1;
      if (a_eff) m_err = 1'b1;
    end else if (a_eff) begin
      do_a = 1'b1;
    end else if (ne) begin
      do_pop = 1'b1;
    end
    if (do_pop || !ne) begin
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      m_starve++;
      if (m_starve == STARVE_LIMIT) m_stall = 1'b1;
    end
    if (do_a) begin
      m_we   = 1'b1;
      m_addr = bus.a_addr_i;
      m_data = bus.a_data_i;
    end else if (do_pop) begin
      e      = mq.pop_front();
      m_we   = 1'b1;
      m_addr = e.addr;
      m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (bus.b_valid_i && rdy && bus.b_addr_i != 5'd0) begin
      e.addr = bus.b_addr_i;
      e.data = bus.b_data_i;
      mq.push_back(e);
    end
  endtask

  // Checks combinational outputs before the edge, clocks once, then checks registered outputs.
  task automatic tick();
    bit rdy;
    #1;
    rdy = !rst_i && (mq.size() < DEPTH);
    check("cyc.b_ready", bus.b_ready_o, rdy);
    check("cyc.qs_pending", bus.qs_pending_o, pend(bus.qs_addr_i));
    check("cyc.qt_pending", bus.qt_pending_o, pend(bus.qt_addr_i));
    check("cyc.qd_pending", bus.qd_pending_o, pend(bus.qd_addr_i));
    if (rst_i) model_reset();
    else       model_step(rdy);
    @(posedge clk_i);
    #1;
    check("cyc.RegWrite", bus.RegWrite_o, m_we);
    check("cyc.RDaddr", bus.RDaddr_o, m_addr);
    check("cyc.RDdata", bus.RDdata_o, m_data);
    check("cyc.stall", bus.stall_o, m_stall);
    check("cyc.err", bus.err_o, m_err);
  endtask

  task automatic set_idle();
    bus.a_valid_i = 1'b0;
    bus.a_addr_i  = 5'd0;
    bus.a_data_i  = 32'd0;
    bus.b_valid_i = 1'b0;
    bus.b_addr_i  = 5'd0;
    bus.b_data_i  = 32'd0;
    bus.qs_addr_i = 5'd0;
    bus.qt_addr_i = 5'd0;
    bus.qd_addr_i = 5'd0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Holds A busy while queueing B entries 1..4; returns edges until stall_o rose.
  task automatic starve_fill(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      bus.a_valid_i = 1'b1;
      bus.a_addr_i  = 5'd10;
      bus.a_data_i  = 32'h100 + 32'(i);
      bus.b_valid_i = (i < 4);
      bus.b_addr_i  = 5'(i + 1);
      bus.b_data_i  = 32'hB0 + 32'(i);
      tick();
      lat++;
      if (i == 3) check("fill.b_ready_full", bus.b_ready_o, 1'b0);
      seen = bus.stall_o;
    end
    bus.b_valid_i = 1'b0;
  endtask

  initial begin
    int lat;
    model_reset();
    set_idle();
    rst_i = 1'b1;
    tick();
    tick();
    check("rst.RegWrite", bus.RegWrite_o, 1'b0);
    check("rst.RDaddr", bus.RDaddr_o, 5'd0);
    check("rst.RDdata", bus.RDdata_o, 32'd0);
    check("rst.stall", bus.stall_o, 1'b0);
    check("rst.err", bus.err_o, 1'b0);
    check("rst.b_ready_in_reset", bus.b_ready_o, 1'b0);
    rst_i = 1'b0;

    // 1: single A write, one-cycle latency
    bus.a_valid_i = 1'b1;
    bus.a_addr_i  = 5'd5;
    bus.a_data_i  = 32'hDEADBEEF;
    tick();
    set_idle();
    check("t1.RegWrite", bus.RegWrite_o, 1'b1);
    check("t1.RDaddr", bus.RDaddr_o, 5'd5);
    check("t1.RDdata", bus.RDdata_o, 32'hDEADBEEF);
    tick();
    check("t1.RegWrite_off", bus.RegWrite_o, 1'b0);

    // 2: B handshake into empty FIFO, scoreboard window
    bus.b_valid_i = 1'b1;
    bus.b_addr_i  = 5'd7;
    bus.b_data_i  = 32'h12345678;
    bus.qs_addr_i = 5'd7;
    #1;
    check("t2.b_ready", bus.b_ready_o, 1'b1);
    tick();
    bus.b_valid_i = 1'b0;
    #1;
    check("t2.pend_queued", bus.qs_pending_o, 1'b1);
    check("t2.no_write_yet", bus.RegWrite_o, 1'b0);
    tick();
    check("t2.RegWrite", bus.RegWrite_o, 1'b1);
    check("t2.RDaddr", bus.RDaddr_o, 5'd7);
    check("t2.RDdata", bus.RDdata_o, 32'h12345678);
    check("t2.pend_writing", bus.qs_pending_o, 1'b1);
    tick();
    check("t2.pend_clear", bus.qs_pending_o, 1'b0);

    // 3: starvation forces a FIFO pop while A backs off
    do_reset();
    starve_fill(lat);
    check("t3.stall_latency", 32'(lat), 32'(STARVE_LIMIT + 1));
    set_idle();
    tick();
    check("t3.forced_we", bus.RegWrite_o, 1'b1);
    check("t3.forced_addr", bus.RDaddr_o, 5'd1);
    check("t3.stall_off", bus.stall_o, 1'b0);
    check("t3.err_clear", bus.err_o, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("t3.drain_order", bus.RDaddr_o, 5'(k));
    end
    tick();
    check("t3.idle", bus.RegWrite_o, 1'b0);

    // 4: A kept valid during stall is dropped and flags err_o
    do_reset();
    starve_fill(lat);
    bus.a_valid_i = 1'b1;
    bus.a_addr_i  = 5'd11;
    bus.a_data_i  = 32'h55;
    tick();
    check("t4.head_written", bus.RDaddr_o, 5'd1);
    check("t4.err_set", bus.err_o, 1'b1);
    tick();
    check("t4.a_after_stall", bus.RDaddr_o, 5'd11);
    set_idle();
    for (int k = 0; k < 5; k++) tick();
    check("t4.err_sticky", bus.err_o, 1'b1);
    do_reset();
    check("t4.err_reset", bus.err_o, 1'b0);

    // 5: writes to $0 vanish
    bus.a_valid_i = 1'b1;
    bus.a_addr_i  = 5'd0;
    bus.a_data_i  = 32'hFFFFFFFF;
    bus.b_valid_i = 1'b1;
    bus.b_addr_i  = 5'd0;
    bus.b_data_i  = 32'h1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5.no_write", bus.RegWrite_o, 1'b0);
      check("t5.b_accepted", bus.b_ready_o, 1'b1);
      check("t5.qd_zero", bus.qd_pending_o, 1'b0);
    end
    set_idle();
    tick();
    check("t5.still_none", bus.RegWrite_o, 1'b0);

    // 6: reset discards three queued entries
    for (int k = 0; k < 3; k++) begin
      bus.a_valid_i = 1'b1;
      bus.a_addr_i  = 5'd20;
      bus.a_data_i  = 32'(k);
      bus.b_valid_i = 1'b1;
      bus.b_addr_i  = 5'(3 * (k + 1));
      bus.b_data_i  = 32'hC0 + 32'(k);
      tick();
    end
    bus.qd_addr_i = 5'd3;
    #1;
    check("t6.queued_pend", bus.qd_pending_o, 1'b1);
    do_reset();
    tick();
    check("t6.no_write", bus.RegWrite_o, 1'b0);
    check("t6.b_ready", bus.b_ready_o, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      bus.qd_addr_i = 5'(3 * k);
      #1;
      check("t6.qd_cleared", bus.qd_pending_o, 1'b0);
    end

    // Random traffic, first light A load, then heavy A load to provoke starvation.
    for (int i = 0; i < 700; i++) begin
      rst_i         = ($urandom_range(0, 149) == 0);
      bus.a_valid_i = ($urandom_range(0, 99) < ((i < 300) ? 50 : 88));
      bus.a_addr_i  = 5'($urandom_range(0, 7));
      bus.a_data_i  = $urandom;
      bus.b_valid_i = ($urandom_range(0, 99) < 45);
      bus.b_addr_i  = 5'($urandom_range(0, 7));
      bus.b_data_i  = $urandom;
      bus.qs_addr_i = 5'($urandom_range(0, 7));
      bus.qt_addr_i = 5'($urandom_range(0, 7));
      bus.qd_addr_i = 5'($urandom_range(0, 31));
      tick();
    end
    rst_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
